// File: rtl/restoring_divider_n.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned per operation,
// with divide-by-zero and signed-overflow flags and a one-cycle done pulse.
module restoring_divider_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             sq_q;
   logic             sr_q;
   logic             ovf_pend_q;
   logic             dbz_pend_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;
   logic             overflow_q;

   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic [WIDTH-1:0] dvd_abs_s;
   logic [WIDTH-1:0] dvs_abs_s;
   logic             ovf_s;
   logic [WIDTH+1:0] shift_s;
   logic [WIDTH+1:0] trial_s;
   logic             ge_s;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH-1:0] q_fix_s;
   logic [WIDTH-1:0] r_fix_s;

   // Operand magnitudes, one shift-subtract step and final sign correction
   always_comb begin
      dvd_neg_s = signed_op & dividend[WIDTH-1];
      dvs_neg_s = signed_op & divisor[WIDTH-1];
      dvd_abs_s = dvd_neg_s ? (~dividend + ONE_W) : dividend;
      dvs_abs_s = dvs_neg_s ? (~divisor + ONE_W) : divisor;
      ovf_s     = signed_op & (dividend == MIN_NEG) & (divisor == ONES_W);
      // top bit of rem_q is always 0 after a restore step, so W+2 bits hold the trial sign
      shift_s   = {rem_q, dvd_q[WIDTH-1]};
      trial_s   = shift_s - {2'b00, dvs_q};
      ge_s      = ~trial_s[WIDTH+1];
      if (ge_s) begin
         rem_d = trial_s[WIDTH:0];
      end else begin
         rem_d = shift_s[WIDTH:0];
      end
      q_fix_s   = sq_q ? (~dvd_q + ONE_W) : dvd_q;
      r_fix_s   = sr_q ? (~rem_q[WIDTH-1:0] + ONE_W) : rem_q[WIDTH-1:0];
   end

   // Control FSM with registered results and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         count_q       <= {CNT_W{1'b0}};
         rem_q         <= {(WIDTH+1){1'b0}};
         dvd_q         <= ZERO_W;
         dvs_q         <= ZERO_W;
         sq_q          <= 1'b0;
         sr_q          <= 1'b0;
         ovf_pend_q    <= 1'b0;
         dbz_pend_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= ZERO_W;
         remainder_q   <= ZERO_W;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q     <= 1'b1;
                  sq_q       <= dvd_neg_s ^ dvs_neg_s;
                  sr_q       <= dvd_neg_s;
                  ovf_pend_q <= ovf_s;
                  dbz_pend_q <= (divisor == ZERO_W);
                  rem_q      <= {(WIDTH+1){1'b0}};
                  count_q    <= CNT_LOAD;
                  dvs_q      <= dvs_abs_s;
                  if (divisor == ZERO_W) begin
                     // raw dividend is kept so it can be returned unmodified
                     dvd_q   <= dividend;
                     state_q <= FIX;
                  end else begin
                     dvd_q   <= dvd_abs_s;
                     state_q <= CALC;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               rem_q   <= rem_d;
               dvd_q   <= {dvd_q[WIDTH-2:0], ge_s};
               count_q <= count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  state_q <= FIX;
               end else begin
                  state_q <= CALC;
               end
            end
            FIX: begin
               done_q        <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= IDLE;
               div_by_zero_q <= dbz_pend_q;
               overflow_q    <= ovf_pend_q & ~dbz_pend_q;
               if (dbz_pend_q) begin
                  quotient_q  <= ONES_W;
                  remainder_q <= dvd_q;
               end else if (ovf_pend_q) begin
                  quotient_q  <= MIN_NEG;
                  remainder_q <= ZERO_W;
               end else begin
                  quotient_q  <= q_fix_s;
                  remainder_q <= r_fix_s;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;
   assign overflow    = overflow_q;

endmodule

// File: doc/restoring_divider_n.md
Name: restoring_divider_n

Overview:
- Parametrised sequential restoring divider; next generation of the 8-bit repeated-subtraction divider used in the arithmetic datapath.
- Takes dividend and divisor in parallel on a single start strobe and runs shift-subtract, one quotient bit per clock.
- Produces quotient and remainder in signed or unsigned mode, per operation.
- Flags divide-by-zero and signed overflow; signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  dividend; sampled with start.
- divisor  input  WIDTH  divisor; sampled with start.
- busy  output  1  high from the edge accepting start until the edge asserting done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  quotient; held until the next completion.
- remainder  output  WIDTH  remainder; held until the next completion.
- div_by_zero  output  1  divisor was 0 for the last operation; held with results.
- overflow  output  1  signed most-negative / -1 for the last operation; held with results.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0.
  - Internal registers are cleared.
  - Asserting reset mid-operation aborts the operation; no done is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 (edge 0):
  - Capture the sign flags when signed_op=1: sq = dividend MSB XOR divisor MSB; sr = dividend MSB.
  - Capture |dividend| and |divisor| as WIDTH-bit unsigned values. The most negative value maps to 2^(WIDTH-1).
  - Clear the partial remainder (WIDTH+1 bits) and load count = WIDTH.
  - busy goes to 1.
  - Next state: FIX if divisor == 0, else CALC.
- CALC, one edge per iteration:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial = partial remainder - divisor magnitude.
  - If trial >= 0: partial remainder = trial and shift in quotient bit 1. Otherwise restore (keep the shifted value) and shift in 0.
  - Decrement count; leave for FIX when count reaches 1 at the edge.
  - Exactly WIDTH CALC edges occur (edges 1..WIDTH).
- FIX (edge WIDTH+1 for a normal operation):
  - quotient = sq ? -Qmag : Qmag; remainder = sr ? -Rmag : Rmag.
  - Signed results truncate toward zero; the remainder takes the dividend's sign.
  - overflow = signed_op & (dividend == 100..0) & (divisor == all ones). In that case quotient = 100..0 (wrapped) and remainder = 0.
  - done=1 for one cycle, busy=0, next state IDLE.
- Divide by zero (FIX at edge 1):
  - quotient = all ones, remainder = original dividend (unmodified bits), div_by_zero = 1, overflow = 0.
  - done pulses after edge 1.
- Latency:
  - Normal operation: done is high in the cycle after edge WIDTH+1.
  - Divide by zero: done is high in the cycle after edge 1.
- Throughput: start may be re-asserted in the cycle done is high. That cycle is IDLE, so a new operation begins with no gap.
- start while busy=1: ignored; operand inputs are don't-care while busy.
- Output flags and results update only at FIX. Between operations they hold the last values.
- Unsigned mode: no sign handling; overflow is always 0.

Test Plan:
- WIDTH=8, unsigned 200/7 -> done exactly 9 edges after start; quotient=28 (0x1C), remainder=4; flags 0; busy high for those 9 cycles.
- WIDTH=8, signed -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1); signed 7/-2 -> quotient=0xFD, remainder=0x01.
- WIDTH=8, 45/0 in either mode -> done after 1 edge; quotient=0xFF, remainder=0x2D, div_by_zero=1.
- WIDTH=8, signed 0x80/0xFF -> quotient=0x80, remainder=0, overflow=1; same operands unsigned -> quotient=0, remainder=0x80, overflow=0.
- Control: start pulsed mid-CALC with different operands -> ignored, original result returned. Back-to-back start in the done cycle -> second done 9 edges later. rst_n low at edge 4 -> all outputs 0, no done, IDLE.
- WIDTH=16 random sweep of 10k signed/unsigned pairs against a reference model -> all results match; done latency is 17 edges.
